riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Load/store unit between core control decode and data memory. Consumes data_req, data_wr,
//  data_byte (mem_access_size_t) and zero_extnd from the control word, plus ALU address and rs2.
//  Runs a req/gnt/rvalid memory handshake with one transaction outstanding, and stalls the core
//  until completion. Aligns store lanes, and extracts and sign/zero-extends load data for RF writeback (MEM).
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in REQ+WAIT before bus error; 0 disables timeout
// PORTS
//  clk               in   1   core clock
//  rst_n             in   1   asynchronous, active-low reset
//  lsu_req_i         in   1   control.data_req; held stable by core while lsu_stall_o=1
//  lsu_wr_i          in   1   control.data_wr; 1=store, 0=load
//  lsu_size_i        in   2   control.data_byte (BYTE/HALF_WORD/RESERVED/WORD)
//  lsu_zero_extnd_i  in   1   control.zero_extnd; 1=LBU/LHU
//  lsu_addr_i        in   32  byte address from ALU
//  lsu_wdata_i       in   32  rs2 store data
//  lsu_stall_o       out  1   hold PC/RF; =lsu_req_i && state!=DONE
//  lsu_rdata_o       out  32  extended load data, valid while lsu_done_o=1
//  lsu_done_o        out  1   one-cycle completion pulse (state DONE)
//  lsu_misalign_o    out  1   with lsu_done_o: access was misaligned/RESERVED, no memory op
//  lsu_bus_err_o     out  1   with lsu_done_o: timeout expired
//  dmem_req_o        out  1   memory request, held until dmem_gnt_i
//  dmem_we_o         out  1   write enable
//  dmem_be_o         out  4   byte enables
//  dmem_addr_o       out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata_o      out  32  lane-replicated store data
//  dmem_gnt_i        in   1   request accepted
//  dmem_rvalid_i     in   1   response (loads and stores), exactly one per grant
//  dmem_rdata_i      in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counter 0. Async: dmem_req_o drops immediately mid-op.
//  FSM (registered): IDLE -> REQ -> WAIT -> DONE -> IDLE.
//   IDLE: lsu_req_i=1 -> capture addr/be/wdata/we/size/zext. Aligned -> REQ.
//         Misaligned -> DONE, misalign=1. Misaligned = HALF&addr[0] | WORD&addr[1:0]!=0 | RESERVED.
//   REQ: dmem_req_o=1 with registered attributes; gnt -> WAIT.
//   WAIT: rvalid -> latch extended data into lsu_rdata_o -> DONE. rvalid in any other state ignored.
//   DONE: stall low, done=1 for exactly 1 cycle -> IDLE. A new req is accepted in the next IDLE.
//  Min latency req->done: 3 cycles (gnt and rvalid each first-cycle).
//  Timeout: counter counts in REQ/WAIT, clears in IDLE. At TIMEOUT_CYCLES -> DONE, bus_err=1,
//   rdata=0, dmem_req_o deasserted. A late rvalid is then ignored.
//  Byte enables: BYTE 4'b0001<<addr[1:0]; HALF 4'b0011<<{addr[1],1'b0}; WORD 4'b1111.
//  Store data: BYTE {4{wd[7:0]}}; HALF {2{wd[15:0]}}; WORD wd.
//  Load: sh = dmem_rdata_i >> {addr[1:0],3'b000}. BYTE ext of sh[7:0], HALF ext of sh[15:0],
//   WORD sh. Ext is zero if zext, else sign. zext ignored for WORD.
//  Stores: lsu_rdata_o=0 on done. Outputs besides flags/rdata are 0 outside REQ.
//  lsu_req_i dropping mid-op (illegal): transaction still completes; the bench asserts it does not occur.
// STRUCTURE
//  Package riscv_pkg additions: lsu_state_t {IDLE,REQ,WAIT,DONE};
//   lsu_lane_t struct {be[3:0],wdata[31:0]}. Reuse mem_access_size_t.
//  Sub-module riscv_lsu_align: combinational BE/store-replication and load shift/extend.
//   Instantiated once; FSM, counter and capture registers stay in riscv_lsu.
// TESTING
//  1 SW addr=0x1004 wd=0xDEADBEEF, gnt+rvalid immediate -> be=1111, addr=0x1004, done 3 cycles after req.
//  2 LB addr=0x2003, rdata=0x80AABBCC, zext=0 -> be=1000, lsu_rdata=0xFFFFFF80.
//    Same with LBU -> 0x00000080.
//  3 SH addr=0x10 wd=0x1234ABCD -> be=0011, wdata=0xABCDABCD.
//    LH addr=0x12, rdata=0x8001xxxx -> 0xFFFF8001.
//  4 LW addr=0x6 -> no dmem_req_o, done+misalign next cycle; LH addr=0x5 and size=RESERVED likewise.
//  5 gnt delayed 5 cycles, rvalid delayed 3 -> stall held throughout, done once, req high until gnt.
//  6 TIMEOUT_CYCLES=8, no gnt -> bus_err+done at cycle 9; rst_n low mid-WAIT -> IDLE, req=0, late rvalid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the core datapath: memory access sizes plus the load/store unit
// state and lane types.
package riscv_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    RESERVED  = 2'b10,
    WORD      = 2'b11
  } mem_access_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } lsu_lane_t;

  // RESERVED is never a legal access; halves need even and words need 4-byte alignment.
  function automatic logic lsu_misaligned(mem_access_size_t size, logic [1:0] addr_lo);
    case (size)
      BYTE:      return 1'b0;
      HALF_WORD: return addr_lo[0];
      WORD:      return addr_lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load shift and
// sign/zero extension.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  mem_access_size_t st_size,
  input  logic [1:0]       st_addr_lo,
  input  logic [31:0]      st_wdata,
  output lsu_lane_t        st_lane,
  input  mem_access_size_t ld_size,
  input  logic             ld_zext,
  input  logic [1:0]       ld_addr_lo,
  input  logic [31:0]      ld_rdata,
  output logic [31:0]      ld_data
);

  logic [31:0] sh;

  always_comb begin
    st_lane = '0;
    case (st_size)
      BYTE: begin
        st_lane.be    = 4'b0001 << st_addr_lo;
        st_lane.wdata = {4{st_wdata[7:0]}};
      end
      HALF_WORD: begin
        st_lane.be    = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_lane.wdata = {2{st_wdata[15:0]}};
      end
      WORD: begin
        st_lane.be    = 4'b1111;
        st_lane.wdata = st_wdata;
      end
      default: st_lane = '0;
    endcase
  end

  assign sh = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = sh;
    case (ld_size)
      BYTE:      ld_data = {{24{~ld_zext & sh[7]}}, sh[7:0]};
      HALF_WORD: ld_data = {{16{~ld_zext & sh[15]}}, sh[15:0]};
      default:   ld_data = sh;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding req/gnt/rvalid transaction, core stall until done,
// misalignment rejection and request timeout.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_i,
  input  logic        lsu_wr_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_zero_extnd_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_done_o,
  output logic        lsu_misalign_o,
  output logic        lsu_bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q, rdata_q, ld_data;
  lsu_lane_t        lane_q, st_lane;
  mem_access_size_t size_q, size_in;
  logic             we_q, zext_q, misalign_q, bus_err_q;
  logic             misaligned, timeout_hit, in_req;

  assign size_in     = mem_access_size_t'(lsu_size_i);
  assign misaligned  = lsu_misaligned(size_in, lsu_addr_i[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (int'(cnt_q) == TIMEOUT_CYCLES - 1);

  riscv_lsu_align u_align (
    .st_size    (size_in),
    .st_addr_lo (lsu_addr_i[1:0]),
    .st_wdata   (lsu_wdata_i),
    .st_lane    (st_lane),
    .ld_size    (size_q),
    .ld_zext    (zext_q),
    .ld_addr_lo (addr_q[1:0]),
    .ld_rdata   (dmem_rdata_i),
    .ld_data    (ld_data)
  );

  // A response completing on the last allowed cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (lsu_req_i) state_d = misaligned ? DONE : REQ;
      REQ: begin
        if (timeout_hit)     state_d = DONE;
        else if (dmem_gnt_i) state_d = WAIT;
      end
      WAIT: if (dmem_rvalid_i || timeout_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      lane_q     <= '0;
      size_q     <= BYTE;
      we_q       <= 1'b0;
      zext_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == REQ || state_q == WAIT) ? cnt_q + 1'b1 : '0;
      case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            addr_q     <= lsu_addr_i;
            lane_q     <= st_lane;
            size_q     <= size_in;
            we_q       <= lsu_wr_i;
            zext_q     <= lsu_zero_extnd_i;
            misalign_q <= misaligned;
            bus_err_q  <= 1'b0;
            rdata_q    <= '0;
          end
        end
        REQ: if (timeout_hit) bus_err_q <= 1'b1;
        WAIT: begin
          if (dmem_rvalid_i)    rdata_q   <= we_q ? '0 : ld_data;
          else if (timeout_hit) bus_err_q <= 1'b1;
        end
        default: begin
          misalign_q <= 1'b0;
          bus_err_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_req         = (state_q == REQ);
  assign dmem_req_o     = in_req;
  assign dmem_we_o      = in_req & we_q;
  assign dmem_be_o      = in_req ? lane_q.be : 4'b0000;
  assign dmem_addr_o    = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_wdata_o   = in_req ? lane_q.wdata : 32'h0;

  assign lsu_done_o     = (state_q == DONE);
  assign lsu_stall_o    = lsu_req_i && (state_q != DONE);
  assign lsu_rdata_o    = lsu_done_o ? rdata_q : 32'h0;
  assign lsu_misalign_o = misalign_q;
  assign lsu_bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: scoreboarded transactions on a default instance, timeout and
// asynchronous reset scenarios on an instance with an 8-cycle timeout.
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        lsu_req, lsu_wr, lsu_zext, dmem_gnt, dmem_rvalid;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, dmem_rdata;
  logic        stall, done, mis, berr, mreq, mwe;
  logic [3:0]  mbe;
  logic [31:0] rdata, maddr, mwdata;

  logic        t_req, t_gnt, t_rvalid;
  logic        t_stall, t_done, t_mis, t_berr, t_mreq, t_mwe;
  logic [3:0]  t_mbe;
  logic [31:0] t_rdata, t_maddr, t_mwdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    int          lat;
  } exp_t;
  exp_t sb[$];

  riscv_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req), .lsu_wr_i(lsu_wr), .lsu_size_i(lsu_size),
    .lsu_zero_extnd_i(lsu_zext), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_stall_o(stall), .lsu_rdata_o(rdata), .lsu_done_o(done),
    .lsu_misalign_o(mis), .lsu_bus_err_o(berr),
    .dmem_req_o(mreq), .dmem_we_o(mwe), .dmem_be_o(mbe), .dmem_addr_o(maddr),
    .dmem_wdata_o(mwdata), .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i(dmem_rdata)
  );

  riscv_lsu #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(t_req), .lsu_wr_i(lsu_wr), .lsu_size_i(lsu_size),
    .lsu_zero_extnd_i(lsu_zext), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_stall_o(t_stall), .lsu_rdata_o(t_rdata), .lsu_done_o(t_done),
    .lsu_misalign_o(t_mis), .lsu_bus_err_o(t_berr),
    .dmem_req_o(t_mreq), .dmem_we_o(t_mwe), .dmem_be_o(t_mbe), .dmem_addr_o(t_maddr),
    .dmem_wdata_o(t_mwdata), .dmem_gnt_i(t_gnt), .dmem_rvalid_i(t_rvalid),
    .dmem_rdata_i(dmem_rdata)
  );

  // The core must hold lsu_req while the unit stalls it.
  logic prev_stall = 1'b0;
  always @(posedge clk) begin
    if (rst_n) assert (!(prev_stall && !lsu_req && !done)) else $error("FAIL req_drop mid-op");
    prev_stall <= stall;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mreq, mwe, mbe, maddr, mwdata, done, stall, rdata, mis, berr} !== '0) begin
      errors++; $display("FAIL reset_main outputs got %h required 0",
        {mreq, mwe, mbe, maddr, mwdata, done, stall, rdata, mis, berr});
    end
    checks++;
    if ({t_mreq, t_mwe, t_mbe, t_maddr, t_mwdata, t_done, t_stall, t_rdata, t_mis, t_berr} !== '0) begin
      errors++; $display("FAIL reset_to outputs nonzero");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mreq, done, stall, mis, berr} !== 5'b0) begin
      errors++; $display("FAIL post_reset flags got %b required 00000", {mreq, done, stall, mis, berr});
    end
  endtask

  // One transaction on the main instance with a responder that grants after gd
  // request cycles and answers rvd cycles after the grant.
  task automatic txn(input string nm, input logic wr, input logic [1:0] sz, input logic zx,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int gd, input int rvd, input logic [3:0] ebe,
                     input logic [31:0] ewd, input logic [31:0] erd, input logic emis,
                     input int elat);
    exp_t e, got;
    int cyc, gcnt, rcnt, req_cyc, done_cnt, stall_bad;
    bit granted, resp;
    e.we = wr; e.be = ebe; e.addr = {a[31:2], 2'b00}; e.wdata = ewd;
    e.rdata = erd; e.mis = emis; e.lat = elat;
    sb.push_back(e);
    lsu_wr = wr; lsu_size = sz; lsu_zext = zx; lsu_addr = a; lsu_wdata = wd; lsu_req = 1'b1;
    cyc = 0; gcnt = 0; rcnt = 0; req_cyc = 0; done_cnt = 0; stall_bad = 0;
    granted = 0; resp = 0;
    while (done_cnt == 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (done) begin
        done_cnt++;
        got = sb.pop_front();
        checks++;
        if (rdata !== got.rdata) begin errors++; $display("FAIL %s rdata got %h required %h", nm, rdata, got.rdata); end
        checks++;
        if (mis !== got.mis) begin errors++; $display("FAIL %s misalign got %b required %b", nm, mis, got.mis); end
        checks++;
        if (berr !== 1'b0) begin errors++; $display("FAIL %s bus_err got %b required 0", nm, berr); end
        checks++;
        if (cyc != got.lat) begin errors++; $display("FAIL %s latency got %0d required %0d", nm, cyc, got.lat); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL %s stall_at_done got %b required 0", nm, stall); end
        lsu_req = 1'b0;
      end else begin
        if (stall !== 1'b1) stall_bad++;
        if (mreq) begin
          req_cyc++;
          if (req_cyc == 1) begin
            checks++;
            if (mwe !== e.we) begin errors++; $display("FAIL %s we got %b required %b", nm, mwe, e.we); end
            checks++;
            if (mbe !== e.be) begin errors++; $display("FAIL %s be got %b required %b", nm, mbe, e.be); end
            checks++;
            if (maddr !== e.addr) begin errors++; $display("FAIL %s addr got %h required %h", nm, maddr, e.addr); end
            if (e.we) begin
              checks++;
              if (mwdata !== e.wdata) begin errors++; $display("FAIL %s wdata got %h required %h", nm, mwdata, e.wdata); end
            end
          end
          if (gcnt == gd) begin dmem_gnt = 1'b1; granted = 1; end
          else gcnt++;
        end else if (granted && !resp) begin
          if (rcnt == rvd) begin dmem_rvalid = 1'b1; dmem_rdata = rd; resp = 1; end
          else rcnt++;
        end
      end
    end
    if (done_cnt == 0) begin
      void'(sb.pop_front());
      checks++; errors++;
      $display("FAIL %s no done within budget", nm);
    end
    checks++;
    if (req_cyc != (emis ? 0 : gd + 1)) begin
      errors++; $display("FAIL %s req_cycles got %0d required %0d", nm, req_cyc, emis ? 0 : gd + 1);
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL %s stall_low_cycles got %0d required 0", nm, stall_bad); end
    @(posedge clk); #1;
    checks++;
    if ({done, mreq} !== 2'b00) begin errors++; $display("FAIL %s after_done got %b required 00", nm, {done, mreq}); end
  endtask

  task automatic test_store_word();
    txn("sw", 1'b1, 2'd3, 1'b0, 32'h1004, 32'hDEADBEEF, 32'h12345678, 0, 0,
        4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 3);
  endtask

  task automatic test_load_byte();
    txn("lb",  1'b0, 2'd0, 1'b0, 32'h2003, 32'h0, 32'h80AABBCC, 0, 0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    txn("lbu", 1'b0, 2'd0, 1'b1, 32'h2003, 32'h0, 32'h80AABBCC, 0, 0, 4'b1000, 32'h0, 32'h00000080, 1'b0, 3);
    txn("lb1", 1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 32'h80AABBCC, 0, 0, 4'b0010, 32'h0, 32'hFFFFFFBB, 1'b0, 3);
    txn("sb",  1'b1, 2'd0, 1'b0, 32'h0003, 32'h0000005A, 32'h0, 0, 0, 4'b1000, 32'h5A5A5A5A, 32'h0, 1'b0, 3);
  endtask

  task automatic test_half_word();
    txn("sh",  1'b1, 2'd1, 1'b0, 32'h10, 32'h1234ABCD, 32'h0, 0, 0, 4'b0011, 32'hABCDABCD, 32'h0, 1'b0, 3);
    txn("lh",  1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h80015555, 0, 0, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 3);
    txn("lhu", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h80015555, 0, 0, 4'b1100, 32'h0, 32'h00008001, 1'b0, 3);
    txn("lhp", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h12347FFF, 0, 0, 4'b0011, 32'h0, 32'h00007FFF, 1'b0, 3);
    txn("lwz", 1'b0, 2'd3, 1'b1, 32'h08, 32'h0, 32'h89ABCDEF, 0, 0, 4'b1111, 32'h0, 32'h89ABCDEF, 1'b0, 3);
  endtask

  task automatic test_misalign();
    txn("lw_mis",  1'b0, 2'd3, 1'b0, 32'h6, 32'h0, 32'hFFFFFFFF, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
    txn("lh_mis",  1'b0, 2'd1, 1'b0, 32'h5, 32'h0, 32'hFFFFFFFF, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
    txn("rsv_mis", 1'b1, 2'd2, 1'b0, 32'h0, 32'h55, 32'hFFFFFFFF, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
  endtask

  task automatic test_back_to_back();
    txn("sw_slow", 1'b1, 2'd3, 1'b0, 32'h100, 32'hA5A5F00F, 32'h0, 5, 3, 4'b1111, 32'hA5A5F00F, 32'h0, 1'b0, 11);
    txn("lw_slow", 1'b0, 2'd3, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 2, 1, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 6);
  endtask

  task automatic test_timeout();
    int cyc, req_cyc, done_at, extra_done;
    lsu_wr = 1'b0; lsu_size = 2'd3; lsu_zext = 1'b0; lsu_addr = 32'h40;
    dmem_rdata = 32'h77777777; t_gnt = 1'b0; t_rvalid = 1'b0; t_req = 1'b1;
    cyc = 0; req_cyc = 0; done_at = 0;
    while (done_at == 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (t_mreq) req_cyc++;
      if (t_done) begin
        done_at = cyc;
        checks++;
        if ({t_berr, t_mis, t_mreq} !== 3'b100) begin
          errors++; $display("FAIL timeout flags berr/mis/req got %b required 100", {t_berr, t_mis, t_mreq});
        end
        checks++;
        if (t_rdata !== 32'h0) begin errors++; $display("FAIL timeout rdata got %h required 0", t_rdata); end
        t_req = 1'b0;
      end
    end
    checks++;
    if (done_at != 9) begin errors++; $display("FAIL timeout done_cycle got %0d required 9", done_at); end
    checks++;
    if (req_cyc != 8) begin errors++; $display("FAIL timeout req_cycles got %0d required 8", req_cyc); end
    extra_done = 0;
    @(posedge clk); #1;
    t_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      t_rvalid = 1'b0;
      if (t_done || t_mreq) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin errors++; $display("FAIL late_rvalid activity got %0d required 0", extra_done); end
  endtask

  task automatic test_async_reset();
    int bad;
    lsu_wr = 1'b1; lsu_size = 2'd3; lsu_addr = 32'h44; lsu_wdata = 32'h0BADF00D;
    t_gnt = 1'b0; t_rvalid = 1'b0; t_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (t_mreq !== 1'b1) begin errors++; $display("FAIL areset_req_pre got %b required 1", t_mreq); end
    rst_n = 1'b0; t_req = 1'b0;
    #1;
    checks++;
    if ({t_mreq, t_mwe, t_mbe} !== 6'b0) begin
      errors++; $display("FAIL areset_req_drop got %b required 000000", {t_mreq, t_mwe, t_mbe});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; t_req = 1'b1;
    @(posedge clk); #1;
    t_gnt = 1'b1;
    @(posedge clk); #1;
    t_gnt = 1'b0;
    checks++;
    if ({t_mreq, t_stall} !== 2'b01) begin
      errors++; $display("FAIL areset_wait_state req/stall got %b required 01", {t_mreq, t_stall});
    end
    rst_n = 1'b0; t_req = 1'b0;
    #1;
    checks++;
    if ({t_mreq, t_done, t_stall, t_berr} !== 4'b0) begin
      errors++; $display("FAIL areset_wait got %b required 0000", {t_mreq, t_done, t_stall, t_berr});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    t_rvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      t_rvalid = 1'b0;
      if (t_done || t_mreq) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL areset_late_rvalid activity got %0d required 0", bad); end
  endtask

  initial begin
    lsu_req = 1'b0; lsu_wr = 1'b0; lsu_size = 2'd0; lsu_zext = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; dmem_rdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    t_req = 1'b0; t_gnt = 1'b0; t_rvalid = 1'b0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_half_word();
    test_misalign();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
